// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD types and elaboration-time BCD helpers
package clock_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;
  localparam int BCD_MAX_W  = BCD_W * MAX_DIGITS;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic [BCD_MAX_W-1:0] to_bcd(input int value);
    logic [BCD_MAX_W-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [BCD_MAX_W-1:0] v, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && v[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Valid BCD vectors order the same way as their decimal values.
  function automatic logic bcd_in_range(input logic [BCD_MAX_W-1:0] v,
                                        input logic [BCD_MAX_W-1:0] lo,
                                        input logic [BCD_MAX_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// rtl/bcd_digit_step.sv - combinational single-digit BCD increment/decrement
module bcd_digit_step
  import clock_pkg::*;
(
  input  bcd_digit_t i_digit,
  input  logic       i_step,
  input  logic       i_dir,
  output bcd_digit_t o_digit,
  output logic       o_step
);

  always_comb begin
    o_digit = i_digit;
    o_step  = 1'b0;
    if (i_step) begin
      if (!i_dir) begin
        if (i_digit == 4'd9) begin
          o_digit = 4'd0;
          o_step  = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == 4'd0) begin
          o_digit = 4'd9;
          o_step  = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - multi-digit BCD counter with programmable range, load and wrap pulses
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  tick,
  input  logic                  dir,
  input  logic                  load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [BCD_MAX_W-1:0] MIN_FULL = to_bcd(MIN_VAL);
  localparam logic [BCD_MAX_W-1:0] MAX_FULL = to_bcd(MAX_VAL);
  localparam logic [W-1:0] MIN_BCD = MIN_FULL[W-1:0];
  localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];

  logic [W-1:0]    r_count;
  logic            r_carry;
  logic            r_borrow;
  logic            r_load_err;
  logic [W-1:0]    w_next;
  logic [DIGITS:0] w_step;
  logic            w_load_ok;
  logic            w_unused_top;

  // Ripple chain: digit 0 always steps, higher digits step on a 9->0 / 0->9 roll.
  assign w_step[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_step u_step (
      .i_digit (r_count[gi*BCD_W +: BCD_W]),
      .i_step  (w_step[gi]),
      .i_dir   (dir),
      .o_digit (w_next[gi*BCD_W +: BCD_W]),
      .o_step  (w_step[gi+1])
    );
  end
  assign w_unused_top = w_step[DIGITS];

  assign w_load_ok = bcd_valid(BCD_MAX_W'(load_val), DIGITS) &&
                     bcd_in_range(BCD_MAX_W'(load_val), MIN_FULL, MAX_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= MIN_BCD;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        if (w_load_ok) r_count <= load_val;
        else           r_load_err <= 1'b1;
      end else if (en && tick) begin
        if (!dir && r_count == MAX_BCD) begin
          r_count <= MIN_BCD;
          r_carry <= 1'b1;
        end else if (dir && r_count == MIN_BCD) begin
          r_count  <= MAX_BCD;
          r_borrow <= 1'b1;
        end else begin
          r_count <= w_next;
        end
      end
    end
  end

  assign count    = r_count;
  assign carry    = r_carry;
  assign borrow   = r_borrow;
  assign load_err = r_load_err;

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised multi-digit BCD counter with programmable count range, up/down direction, parallel load and registered wrap pulses.
- Generalises the clock's seconds counter so one block covers seconds (00–59), minutes (00–59) and hours (00–23 or 01–12).
- Instances chain: one stage's wrap pulse drives the next stage's tick input.

Parameters:
- DIGITS, 2, number of BCD digits; count width is 4*DIGITS.
- MIN_VAL, 0, lowest count value (decimal integer); 1 for 12-hour mode.
- MAX_VAL, 59, highest count value (decimal integer); must satisfy MIN_VAL < MAX_VAL < 10**DIGITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  count enable; when low, tick is ignored but load still operates.
- tick  in  1  single-cycle step request from the clock divider or the previous stage's wrap pulse.
- dir  in  1  0 = count up, 1 = count down; sampled with tick.
- load  in  1  parallel load strobe.
- load_val  in  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
- count  out  4*DIGITS  current BCD value; digit 0 (least significant) in bits [3:0].
- carry  out  1  one-cycle pulse on an up-wrap MAX_VAL->MIN_VAL.
- borrow  out  1  one-cycle pulse on a down-wrap MIN_VAL->MAX_VAL.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (asynchronous, active-high): count = BCD(MIN_VAL); carry = borrow = load_err = 0. Reset asserted mid-operation overrides everything within the same cycle.
- Every digit of count is always valid BCD (0–9). No transient 10 state ever appears on count.
- Priority per rising clk edge: rst > load > (en & tick) > hold.
- Load:
  - Accepted if every digit of load_val <= 9 and MIN_VAL <= value <= MAX_VAL.
  - Accepted: count = load_val on the next edge; carry = borrow = 0.
  - Rejected: count holds; load_err = 1 for exactly one cycle.
  - A load in the same cycle as tick discards the tick; no carry or borrow is produced.
- Count up (en & tick & !dir):
  - If count == MAX_VAL: count = MIN_VAL and carry = 1 on the same edge.
  - Otherwise count increments by one with decimal ripple (digit 9 -> 0 and increments the next digit).
- Count down (en & tick & dir):
  - If count == MIN_VAL: count = MAX_VAL and borrow = 1.
  - Otherwise count decrements by one with decimal ripple (digit 0 -> 9 and decrements the next digit).
- Step latency: count updates on the edge where tick is sampled high (latency 1).
- Wrap pulses: carry and borrow are registered, high for exactly one cycle, and coincident with the wrapped count value. A downstream stage sees them one cycle after the wrap.
- Pulse widths:
  - tick held high for N cycles produces N steps.
  - Back-to-back wraps produce one pulse per wrap.
  - carry and borrow are never high in the same cycle.
- Not-enabled: when en = 0, count holds and carry = borrow = 0, regardless of tick.
- Arithmetic: per-digit 4-bit logic only; no binary-to-BCD conversion. MIN_VAL and MAX_VAL are converted to BCD constants at elaboration.

Decomposition:
- Shared package clock_pkg:
  - BCD_W = 4.
  - BCD digit type.
  - Elaboration-time function converting an integer to a packed BCD vector.
  - Function validating a BCD vector.
- Sub-module bcd_digit_step, one instance per digit:
  - Inputs: 4-bit digit, step-in, dir.
  - Outputs: next digit, step-out (9->0 up or 0->9 down).
  - Combinational; all state stays in bcd_mod_counter.

Test Plan:
- Defaults (0..59): reset, then 60 ticks up -> count returns to 0x00; carry = 1 exactly once, in the cycle count becomes 0x00 after 0x59.
- MIN_VAL = 1, MAX_VAL = 12: from 0x01, one tick with dir = 1 -> count = 0x12, borrow pulses once. From 0x09, one tick up -> 0x10, no carry.
- Defaults: load_val = 0x7A -> load_err pulses, count holds. load_val = 0x60 -> rejected. load_val = 0x45 -> count = 0x45 next cycle.
- Defaults: load with 0x58 and tick in the same cycle while count = 0x59 -> count = 0x58, carry stays 0.
- Defaults: count at 0x37, en = 0, 5 ticks -> count stays 0x37. Assert rst asynchronously between edges -> count = 0x00 immediately, with no carry.
- MIN_VAL = 0, MAX_VAL = 23: chain two instances (minutes carry -> hours tick). 1440 minute ticks from 00:00 -> both stages back at 0x00; hours carry pulses once.
